muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the pipelined MIPS core, sitting directly downstream of the register file read ports in the EX stage. It consumes the rs/rt operands, runs MULT/MULTU/DIV/DIVU over 33 cycles, and holds the architectural HI/LO registers. MTHI/MTLO writes complete in a single cycle. While it is busy, `busy` stalls the front end.

## Interface
- `WIDTH`, 32: operand width; HI/LO width. Only 32 is supported.
- `CYCLES`, 32: iteration count. Must equal `WIDTH`.
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request valid; sampled only when idle.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- `rs_data`  in  32  operand A (dividend, multiplicand, or MTHI/MTLO source).
- `rt_data`  in  32  operand B (divisor or multiplier).
- `cancel`  in  1  synchronous abort, e.g. on a pipeline flush.
- `busy`  out  1  high while an iterative op is in flight.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated.
- `hi`  out  32  HI register, registered output.
- `lo`  out  32  LO register, registered output.

## Operation
- **Reset values:** state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0.
- **FSM states:** IDLE, MUL, DIV, FIX.
- **IDLE + start + MULT/MULTU:**
  - Latch the operands. For MULT, latch absolute values and record sign = rs[31]^rt[31].
  - Go to MUL with counter=0.
- **IDLE + start + DIV/DIVU:**
  - Latch the operands. For DIV, latch absolute values and record the quotient sign (rs[31]^rt[31]) and the remainder sign (rs[31]).
  - Record divide-by-zero (rt==0).
  - Go to DIV with counter=0.
- **IDLE + start + MTHI/MTLO:** `hi`/`lo` ← `rs_data` at that edge; `done` pulses next cycle; `busy` never rises.
- **IDLE + start + op 110/111:** no state change and no `done`.
- **MUL:** one unsigned shift-add step per cycle on a 64-bit accumulator. After `CYCLES` steps, go to FIX.
- **DIV:** one unsigned restoring step per cycle, producing a 32-bit quotient and remainder. After `CYCLES` steps, go to FIX.
- **FIX (one cycle), at its edge:**
  - Multiply: {hi,lo} ← signed ? two's-complement negation of the product when sign=1 : product.
  - Divide: lo ← quotient, hi ← remainder, each negated according to its recorded sign.
  - Divide-by-zero (both DIV and DIVU): lo ← 32'hFFFFFFFF, hi ← original `rs_data`. No sign fix is applied.
  - Then return to IDLE and set `done`.
- **Result width:** all arithmetic is modulo 2^64 for products and 2^32 for the quotient and remainder.
  - MULT of 32'h80000000 × 32'h80000000 = 64'h4000000000000000.
  - DIV of 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0 (wraps, no trap).
- **`start` while not IDLE:** ignored. Upstream must hold the instruction while `busy`=1.
- **`cancel` in MUL/DIV/FIX:** return to IDLE at the next edge; `hi`/`lo` unchanged; no `done`.
- **`cancel` and `start` in the same IDLE cycle:** `cancel` wins; the op is dropped, including MTHI/MTLO.
- **`reset` asserted mid-operation:** immediately returns every output to its reset value.
- **`hi`/`lo` update rule:** they change only at the FIX edge or at an MTHI/MTLO edge. MFHI/MFLO read the ports directly and must be stalled while `busy`=1.

## Timing
- **Iterative op:** `start` is sampled at edge E0.
  - `busy`=1 from after E0 through E33, i.e. 33 cycles.
  - Iterations run on E1..E32; FIX runs on E33.
  - `hi`/`lo` are new and `done`=1 in the cycle after E33.
  - `busy`=0 in that same cycle.
- **Throughput:** the earliest next accepted `start` is at E34; back-to-back ops give 34 cycles per op.
- **MTHI/MTLO:** accepted at E0, visible on `hi`/`lo` after E0, `done`=1 after E0 for one cycle. The next `start` can be accepted at E1.
- **`done`:** always exactly one cycle wide; it never coincides with `busy`=1.
- **`busy`:** a registered output that depends only on state, with no combinational path from `start`.

## Test plan
- **MULT, mixed signs:** rs=32'hFFFFFFFD (-3), rt=5 → after 34 cycles `done`=1, hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; `busy` high exactly 33 cycles.
- **MULTU, maximum operands:** rs=rt=32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001. Then MULT with the same operands → hi=0, lo=1.
- **DIV / DIVU signs:** DIV rs=-7 (32'hFFFFFFF9), rt=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU with the same operands → lo=32'h7FFFFFFC, hi=1.
- **Divide by zero:** DIV rs=32'h12345678, rt=0 → lo=32'hFFFFFFFF, hi=32'h12345678, after the normal 34-cycle latency.
- **MTHI/MTLO and ignored start:**
  - MTHI rs=32'hA5A5A5A5 → hi updated next cycle, `done` one cycle, `busy` never high.
  - Then MULT; pulse `start` with MTLO during cycle 10 → lo is unaffected by the MTLO and the MULT result is correct.
- **Cancel and reset mid-operation:**
  - Start DIV, assert `cancel` at cycle 15 → back in IDLE next cycle; hi/lo keep their prior values; no `done`.
  - Start MULT, drop `reset` at cycle 20 → hi=lo=0 and `busy`=0 immediately.
  - A new op after release completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit holding the architectural HI/LO
//               registers. MULT/MULTU run a shift-add loop, DIV/DIVU a
//               restoring loop, each CYCLES steps followed by a one-cycle
//               sign-fix state. MTHI/MTLO write HI/LO in a single cycle.
// Ports       : clk, reset (async, active-low)
//               start, op[2:0], rs_data, rt_data, cancel  -- request side
//               busy, done, hi, lo                        -- status / results
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MUL  = 2'd1;
  localparam logic [1:0] c_DIV  = 2'd2;
  localparam logic [1:0] c_FIX  = 2'd3;

  localparam logic [2:0] c_OP_MULT  = 3'b000;
  localparam logic [2:0] c_OP_MULTU = 3'b001;
  localparam logic [2:0] c_OP_DIV   = 3'b010;
  localparam logic [2:0] c_OP_DIVU  = 3'b011;
  localparam logic [2:0] c_OP_MTHI  = 3'b100;
  localparam logic [2:0] c_OP_MTLO  = 3'b101;

  localparam int              c_CW   = $clog2(CYCLES + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(CYCLES - 1);

  logic [1:0]         r_state, w_state_next;
  logic [c_CW-1:0]    r_count;
  // Multiply: {partial product high, multiplier shifting out at bit 0}.
  // Divide:   {partial remainder, dividend shifting out / quotient in}.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;     // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0]   r_rs_orig;  // raw dividend, returned in HI on divide-by-zero
  logic               r_neg_lo;   // negate product / quotient at FIX
  logic               r_neg_hi;   // negate remainder at FIX
  logic               r_is_div;
  logic               r_dbz;

  logic               w_accept, w_mul_go, w_div_go, w_mthi, w_mtlo, w_commit;
  logic               w_signed;
  logic [WIDTH-1:0]   w_rs_abs, w_rt_abs;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_sub;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;
  logic [2*WIDTH-1:0] w_prod;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; cancel always wins, including over a start in IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_mul_go)      w_state_next = c_MUL;
        else if (w_div_go) w_state_next = c_DIV;
      end
      c_MUL, c_DIV: begin
        if (cancel)                 w_state_next = c_IDLE;
        else if (r_count == c_LAST) w_state_next = c_FIX;
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  // Output / datapath decode
  always_comb begin
    w_accept = (r_state == c_IDLE) && start && !cancel;
    w_mul_go = w_accept && ((op == c_OP_MULT) || (op == c_OP_MULTU));
    w_div_go = w_accept && ((op == c_OP_DIV)  || (op == c_OP_DIVU));
    w_mthi   = w_accept && (op == c_OP_MTHI);
    w_mtlo   = w_accept && (op == c_OP_MTLO);
    w_commit = (r_state == c_FIX) && !cancel;

    w_signed = (op == c_OP_MULT) || (op == c_OP_DIV);
    w_rs_abs = (w_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    w_rt_abs = (w_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

    // Shift-add: add multiplicand into the high half when the multiplier
    // LSB is set, then shift the whole accumulator right by one.
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: the remainder is always below the divisor, so the
    // low WIDTH bits of the difference are exact when the subtract is taken.
    w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;
    w_div_next  = {(w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0]),
                   r_acc[WIDTH-2:0], w_div_ge};

    w_prod = r_neg_lo ? -r_acc : r_acc;
    if (!r_is_div) begin
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end else if (r_dbz) begin
      w_fix_hi = r_rs_orig;
      w_fix_lo = '1;
    end else begin
      w_fix_hi = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      w_fix_lo = r_neg_lo ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_rs_orig <= '0;
      r_neg_lo  <= 1'b0;
      r_neg_hi  <= 1'b0;
      r_is_div  <= 1'b0;
      r_dbz     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (w_mul_go || w_div_go) begin
        r_count   <= '0;
        r_acc     <= {{WIDTH{1'b0}}, (w_mul_go ? w_rt_abs : w_rs_abs)};
        r_opnd    <= w_mul_go ? w_rs_abs : w_rt_abs;
        r_rs_orig <= rs_data;
        r_neg_lo  <= w_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
        r_neg_hi  <= w_signed && rs_data[WIDTH-1];
        r_is_div  <= w_div_go;
        r_dbz     <= (rt_data == '0);
      end else if (r_state == c_MUL) begin
        r_count <= r_count + 1'b1;
        r_acc   <= w_mul_next;
      end else if (r_state == c_DIV) begin
        r_count <= r_count + 1'b1;
        r_acc   <= w_div_next;
      end

      if (w_mthi)        hi <= rs_data;
      else if (w_commit) hi <= w_fix_hi;

      if (w_mtlo)        lo <= rs_data;
      else if (w_commit) lo <= w_fix_lo;

      done <= w_mthi || w_mtlo || w_commit;
      busy <= (w_state_next != c_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Directed and random
//               operations are compared against an arithmetic reference model
//               of HI/LO, together with latency, busy width and done shape.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a, b, eh, el;
  } vec_t;

  vec_t dirv [9] = '{
    '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1},
    '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
    '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001},
    '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC},
    '{3'd2, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF},
    '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
    '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
    '{3'd3, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'hFFFFFFFF}
  };

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .CYCLES(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .cancel  (cancel),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  // Reference model: architectural HI/LO effect of one completed operation
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
      3'd2: if (b == 0) begin m_hi = a; m_lo = '1; end
            else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      3'd3: if (b == 0) begin m_hi = a; m_lo = '1; end
            else begin m_lo = a / b; m_hi = a % b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op and wait (bounded) for done; reports latency in cycles after
  // the accepting edge, cycles with busy high, and done one cycle later.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt, output logic dn_after);
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end while (done !== 1'b1 && lat < 60);
    @(negedge clk);
    dn_after = done;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h expected 0", hi); end
    n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h expected 0", lo); end
    reset = 1'b1;
  endtask

  task automatic test_directed;
    int lat, bcnt; logic dn2;
    foreach (dirv[i]) begin
      run_op(dirv[i].o, dirv[i].a, dirv[i].b, lat, bcnt, dn2);
      model(dirv[i].o, dirv[i].a, dirv[i].b);
      n_vec++; if (lat !== 34) begin n_err++; $display("FAIL dir%0d_latency: got %0d expected 34", i, lat); end
      n_vec++; if (bcnt !== 33) begin n_err++; $display("FAIL dir%0d_busy_cycles: got %0d expected 33", i, bcnt); end
      n_vec++; if (dn2 !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_width: got %b expected 0", i, dn2); end
      n_vec++; if (hi !== dirv[i].eh) begin n_err++; $display("FAIL dir%0d_hi: got %h expected %h", i, hi, dirv[i].eh); end
      n_vec++; if (lo !== dirv[i].el) begin n_err++; $display("FAIL dir%0d_lo: got %h expected %h", i, lo, dirv[i].el); end
    end
  endtask

  task automatic test_mt_and_ignored_start;
    int lat, bcnt; logic dn2;
    logic [31:0] a, b;
    run_op(3'd4, 32'hA5A5A5A5, 32'h0, lat, bcnt, dn2);
    model(3'd4, 32'hA5A5A5A5, 32'h0);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL mthi_latency: got %0d expected 1", lat); end
    n_vec++; if (bcnt !== 0) begin n_err++; $display("FAIL mthi_busy: got %0d expected 0", bcnt); end
    n_vec++; if (dn2 !== 1'b0) begin n_err++; $display("FAIL mthi_done_width: got %b expected 0", dn2); end
    n_vec++; if (hi !== m_hi) begin n_err++; $display("FAIL mthi_hi: got %h expected %h", hi, m_hi); end
    n_vec++; if (lo !== m_lo) begin n_err++; $display("FAIL mthi_lo: got %h expected %h", lo, m_lo); end

    // MULT with an MTLO pulsed mid-operation; the MTLO must be dropped
    a = $urandom; b = $urandom;
    @(negedge clk);
    op = 3'd0; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (lat == 10) begin start = 1'b1; op = 3'd5; rs_data = 32'h0BADF00D; end
      else start = 1'b0;
    end while (done !== 1'b1 && lat < 60);
    start = 1'b0;
    model(3'd0, a, b);
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL ign_latency: got %0d expected 34", lat); end
    n_vec++; if (bcnt !== 33) begin n_err++; $display("FAIL ign_busy_cycles: got %0d expected 33", bcnt); end
    n_vec++; if (hi !== m_hi) begin n_err++; $display("FAIL ign_hi: got %h expected %h", hi, m_hi); end
    n_vec++; if (lo !== m_lo) begin n_err++; $display("FAIL ign_lo: got %h expected %h", lo, m_lo); end
  endtask

  task automatic test_noop;
    int dn_cnt, b_cnt;
    dn_cnt = 0; b_cnt = 0;
    @(negedge clk);
    op = 3'd6; rs_data = $urandom; rt_data = $urandom; start = 1'b1;
    @(posedge clk);
    #1 op = 3'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) dn_cnt++;
      if (busy) b_cnt++;
    end
    n_vec++; if (dn_cnt !== 0) begin n_err++; $display("FAIL noop_done: got %0d pulses expected 0", dn_cnt); end
    n_vec++; if (b_cnt !== 0) begin n_err++; $display("FAIL noop_busy: got %0d cycles expected 0", b_cnt); end
    n_vec++; if (hi !== m_hi || lo !== m_lo) begin n_err++; $display("FAIL noop_hilo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_cancel;
    int dn_cnt, b_cnt;
    dn_cnt = 0; b_cnt = 0;
    @(negedge clk);
    op = 3'd2; rs_data = $urandom; rt_data = $urandom_range(1, 1000); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cancel_busy: got %b expected 0", busy); end
    n_vec++; if (hi !== m_hi || lo !== m_lo) begin n_err++; $display("FAIL cancel_hilo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo); end
    repeat (40) begin
      @(negedge clk);
      if (done) dn_cnt++;
    end
    n_vec++; if (dn_cnt !== 0) begin n_err++; $display("FAIL cancel_done: got %0d pulses expected 0", dn_cnt); end

    // cancel and start together in IDLE: both an MTHI and a MULT are dropped
    dn_cnt = 0;
    @(negedge clk);
    op = 3'd4; rs_data = ~m_hi; start = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1 op = 3'd0;
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn_cnt++;
      if (busy) b_cnt++;
    end
    n_vec++; if (dn_cnt !== 0 || b_cnt !== 0) begin n_err++; $display("FAIL cancel_start_idle: got done=%0d busy=%0d expected 0/0", dn_cnt, b_cnt); end
    n_vec++; if (hi !== m_hi || lo !== m_lo) begin n_err++; $display("FAIL cancel_start_hilo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt; logic dn2;
    logic [31:0] a, b;
    @(negedge clk);
    op = 3'd0; rs_data = $urandom; rt_data = $urandom; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL rstmid_hilo: got %h_%h expected 0_0", hi, lo); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rstmid_flags: got busy=%b done=%b expected 0/0", busy, done); end
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    a = $urandom; b = $urandom_range(1, 70000);
    run_op(3'd3, a, b, lat, bcnt, dn2);
    model(3'd3, a, b);
    n_vec++; if (lat !== 34 || bcnt !== 33) begin n_err++; $display("FAIL rstmid_after_timing: got lat=%0d busy=%0d expected 34/33", lat, bcnt); end
    n_vec++; if (hi !== m_hi || lo !== m_lo) begin n_err++; $display("FAIL rstmid_after_hilo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_random;
    int lat, bcnt; logic dn2;
    logic [2:0]  o;
    logic [31:0] a, b;
    int          sel;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) a = 32'h80000000;
      if (sel == 1) b = 32'h0;
      if (sel == 2) b = 32'hFFFFFFFF;
      if (sel == 3) b = 32'($urandom_range(1, 300));
      run_op(o, a, b, lat, bcnt, dn2);
      model(o, a, b);
      n_vec++; if (lat !== ((o >= 3'd4) ? 1 : 34)) begin n_err++; $display("FAIL rnd%0d_latency op=%0d: got %0d", i, o, lat); end
      n_vec++; if (bcnt !== ((o >= 3'd4) ? 0 : 33)) begin n_err++; $display("FAIL rnd%0d_busy op=%0d: got %0d", i, o, bcnt); end
      n_vec++; if (dn2 !== 1'b0) begin n_err++; $display("FAIL rnd%0d_done_width: got %b expected 0", i, dn2); end
      n_vec++; if (hi !== m_hi || lo !== m_lo) begin
        n_err++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, o, a, b, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] a1, b1, a2, b2, x, y;
    // MTHI accepted at E0, MTLO at E1
    x = $urandom; y = $urandom;
    @(negedge clk);
    op = 3'd4; rs_data = x; start = 1'b1;
    @(posedge clk);
    #1 op = 3'd5; rs_data = y;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    model(3'd4, x, 32'h0); model(3'd5, y, 32'h0);
    n_vec++; if (done !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
      n_err++; $display("FAIL b2b_mt: got done=%b %h_%h expected 1 %h_%h", done, hi, lo, m_hi, m_lo);
    end

    // Held start: second MULTU accepted at E34, 34 cycles after the first
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    @(negedge clk);
    op = 3'd1; rs_data = a1; rt_data = b1; start = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin @(negedge clk); lat++; end while (done !== 1'b1 && lat < 60);
    model(3'd1, a1, b1);
    n_vec++; if (lat !== 34 || hi !== m_hi || lo !== m_lo) begin
      n_err++; $display("FAIL b2b_first: got lat=%0d %h_%h expected 34 %h_%h", lat, hi, lo, m_hi, m_lo);
    end
    rs_data = a2; rt_data = b2;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (done !== 1'b1 && lat < 60);
    model(3'd1, a2, b2);
    n_vec++; if (lat !== 34 || hi !== m_hi || lo !== m_lo) begin
      n_err++; $display("FAIL b2b_second: got lat=%0d %h_%h expected 34 %h_%h", lat, hi, lo, m_hi, m_lo);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_mt_and_ignored_start;
    test_noop;
    test_cancel;
    test_reset_mid;
    test_random;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
